// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions: receive FSM state encoding and the default frame
// constants used by the baud generator, the transmitter and the receiver.
// No ports; imported with `import uart_pkg::*;`.
// ----------------------------------------------------------------------------
package uart_pkg;

  // baud_tick pulses per bit period; the baud generator must use the same value
  localparam int UART_OVERSAMPLE = 16;
  // payload bits per frame, LSB first
  localparam int UART_DATA_BITS  = 8;

  // Receive FSM states. The encoding is also visible on the receiver's
  // rx_state debug output, so keep the values stable.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } rx_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// ----------------------------------------------------------------------------
// uart_rx_sync
// Two-flop synchroniser for the asynchronous serial input. Both flops reset
// to 1 so an idle (high) line is seen right after reset and no false start
// bit is detected.
// Ports:
//   clock   in   system clock
//   reset_n in   asynchronous active-low reset
//   rx      in   raw serial line, asynchronous to clock
//   rx_s    out  synchronised serial line
// ----------------------------------------------------------------------------
module uart_rx_sync (
  input  logic clock,
  input  logic reset_n,
  input  logic rx,
  output logic rx_s
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= rx;
      sync_q <= meta_q;
    end
  end

  assign rx_s = sync_q;

endmodule

// File: rtl/uart_rx_core.sv
// ----------------------------------------------------------------------------
// uart_rx_core
// UART receive engine. Consumes the 16x oversample baud_tick, recovers
// start + DATA_BITS (+ optional parity) + stop frames from rx and presents
// each byte on a valid/ready output. Reports framing errors and overruns.
//
// Optional feature: define UART_RX_PARITY_EN to add a parity bit after the
// data bits (PARITY_ODD parameter, 0 = even) and the parity_err output.
//
// Ports:
//   clock      in   system clock
//   reset_n    in   asynchronous active-low reset
//   baud_tick  in   1-clock pulse, OVERSAMPLE per bit period
//   rx         in   serial line, asynchronous, idle high
//   rx_data    out  received payload, stable while rx_valid=1
//   rx_valid   out  payload available
//   rx_ready   in   consumer ready
//   frame_err  out  1-clock pulse: stop bit sampled 0
//   overrun    out  1-clock pulse: byte completed while previous not taken
//   parity_err out  1-clock pulse: parity mismatch (UART_RX_PARITY_EN only)
//   busy       out  FSM not in IDLE
//   rx_state   out  FSM state (debug)
//
// Handshake: a byte transfers on every rising clock edge where
// rx_valid && rx_ready. rx_valid never depends combinationally on rx_ready,
// and rx_data does not change while rx_valid is high unless the same edge
// transfers the old byte and loads a new one.
// ----------------------------------------------------------------------------
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = UART_DATA_BITS,
  parameter int OVERSAMPLE = UART_OVERSAMPLE
`ifdef UART_RX_PARITY_EN
  , parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 baud_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun,
`ifdef UART_RX_PARITY_EN
  output logic                 parity_err,
`endif
  output logic                 busy,
  output logic [2:0]           rx_state
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  // START decides at the middle of the start bit; later bits are sampled one
  // full bit period apart, i.e. at their middles.
  localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

  logic                 rx_s;
  rx_state_e            state_q, state_d;
  logic [TW-1:0]        tick_q, tick_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 fe_q, fe_d;
  logic                 ov_q, ov_d;
  logic                 deliver;
`ifdef UART_RX_PARITY_EN
  logic                 pbit_q, pbit_d;
  logic                 pe_q, pe_d;
`endif

  uart_rx_sync u_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .rx      (rx),
    .rx_s    (rx_s)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      fe_q    <= 1'b0;
      ov_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      pbit_q  <= 1'b0;
      pe_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      fe_q    <= fe_d;
      ov_q    <= ov_d;
`ifdef UART_RX_PARITY_EN
      pbit_q  <= pbit_d;
      pe_q    <= pe_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    // A pending byte is dropped from the output once the consumer takes it.
    valid_d = valid_q & ~rx_ready;
    fe_d    = 1'b0;
    ov_d    = 1'b0;
    deliver = 1'b0;
`ifdef UART_RX_PARITY_EN
    pbit_d  = pbit_q;
    pe_d    = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (baud_tick && !rx_s) begin
          state_d = ST_START;
          tick_d  = '0;
        end
      end

      ST_START: begin
        if (baud_tick) begin
          if (tick_q == HALF_LAST) begin
            if (!rx_s) begin
              state_d = ST_DATA;
              tick_d  = '0;
              bit_d   = '0;
            end else begin
              // line went high again before mid start bit: a glitch
              state_d = ST_IDLE;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end

      ST_DATA: begin
        if (baud_tick) begin
          if (tick_q == FULL_LAST) begin
            tick_d = '0;
            // LSB arrives first, so shifting in at the MSB leaves it at bit 0
            shreg_d = {rx_s, shreg_q[DATA_BITS-1:1]};
            if (bit_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
              state_d = ST_PARITY;
`else
              state_d = ST_STOP;
`endif
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (baud_tick) begin
          if (tick_q == FULL_LAST) begin
            tick_d  = '0;
            pbit_d  = rx_s;
            state_d = ST_STOP;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
`endif

      ST_STOP: begin
        if (baud_tick) begin
          if (tick_q == FULL_LAST) begin
            tick_d = '0;
            if (!rx_s) begin
              fe_d    = 1'b1;
              state_d = ST_BREAK;
            end
`ifdef UART_RX_PARITY_EN
            else if ((^shreg_q ^ PARITY_ODD) != pbit_q) begin
              pe_d    = 1'b1;
              state_d = ST_IDLE;
            end
`endif
            else begin
              deliver = 1'b1;
              state_d = ST_IDLE;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end

      ST_BREAK: begin
        // a held-low line must not be taken as a new start bit
        if (rx_s) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // The output register can take a new byte when empty or when the old byte
    // is being taken on this same edge; otherwise the new byte is lost.
    if (deliver) begin
      if (!valid_q || rx_ready) begin
        data_d  = shreg_q;
        valid_d = 1'b1;
      end else begin
        ov_d = 1'b1;
      end
    end
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = fe_q;
  assign overrun   = ov_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = pe_q;
`endif
  assign busy      = (state_q != ST_IDLE);
  assign rx_state  = state_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// ----------------------------------------------------------------------------
// tb_uart_rx_core
// Self-checking bench for uart_rx_core. baud_tick is produced every TICK_DIV
// clocks so that full frames stay short. Serial frames are driven bit by bit;
// a reference model decides from the frame contents whether each frame yields
// a byte, a framing error or a parity error, and a monitor collects what the
// design hands over on its valid/ready output.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_rx_core;
  import uart_pkg::*;

  localparam int DB       = 8;
  localparam int OS       = 16;
  localparam int TICK_DIV = 4;
  localparam int BIT_CLKS = OS * TICK_DIV;
`ifdef UART_RX_PARITY_EN
  localparam int PARITY_ODD_TB = 0;
`endif

  logic          clock     = 1'b0;
  logic          reset_n   = 1'b1;
  logic          baud_tick = 1'b0;
  logic          rx        = 1'b1;
  logic          rx_ready  = 1'b1;
  logic [DB-1:0] rx_data;
  logic          rx_valid;
  logic          frame_err;
  logic          overrun;
  logic          busy;
  logic [2:0]    rx_state;
`ifdef UART_RX_PARITY_EN
  logic          parity_err;
`endif

  int tests = 0;
  int fails = 0;

  // scoreboard
  logic [DB-1:0] exp_q[$];
  logic [DB-1:0] got_q[$];
  int valid_cycles = 0;
  int fe_cnt = 0, ov_cnt = 0, pe_cnt = 0;
  int fe_exp = 0, ov_exp = 0, pe_exp = 0;
  int tick_phase = 0;

  uart_rx_core #(
    .DATA_BITS  (DB),
    .OVERSAMPLE (OS)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .baud_tick  (baud_tick),
    .rx         (rx),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .frame_err  (frame_err),
    .overrun    (overrun),
`ifdef UART_RX_PARITY_EN
    .parity_err (parity_err),
`endif
    .busy       (busy),
    .rx_state   (rx_state)
  );

  // ---------------- clock / reset / tick ----------------
  always #10 clock = ~clock;

  always @(negedge clock) begin
    tick_phase = (tick_phase == TICK_DIV - 1) ? 0 : tick_phase + 1;
    baud_tick  = (tick_phase == 0);
  end

  initial begin
    #(20 * 90000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- monitor ----------------
  // Samples late in the low phase: inputs set at the falling edge are already
  // visible, so a transfer is recorded exactly when the design sees one.
  always @(negedge clock) begin
    #5;
    if (reset_n) begin
      if (rx_valid) valid_cycles++;
      if (rx_valid && rx_ready) got_q.push_back(rx_data);
      if (frame_err) fe_cnt++;
      if (overrun) ov_cnt++;
`ifdef UART_RX_PARITY_EN
      if (parity_err) pe_cnt++;
`endif
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_sb(input string tag);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    while (exp_q.size() > 0 && got_q.size() > 0)
      check({tag, "_byte"}, got_q.pop_front(), exp_q.pop_front());
    exp_q.delete();
    got_q.delete();
    check({tag, "_frame_err"}, fe_cnt, fe_exp);
    check({tag, "_overrun"}, ov_cnt, ov_exp);
    check({tag, "_parity_err"}, pe_cnt, pe_exp);
  endtask

  // ---------------- drivers ----------------
  task automatic step();
    @(negedge clock);
    #2;
  endtask

  task automatic hold(input int n);
    repeat (n) step();
  endtask

  task automatic wait_state(input logic [2:0] st, input int bound, input string tag);
    int n = 0;
    while (rx_state !== st && n < bound) begin
      step();
      n++;
    end
    check(tag, rx_state, st);
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    hold(BIT_CLKS);
  endtask

  // start bit, data LSB first, then parity when enabled
  task automatic send_body(input logic [DB-1:0] d, input logic par);
    send_bit(1'b0);
    for (int i = 0; i < DB; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(par);
`else
    if (par === 1'bx) rx = 1'b1;
`endif
  endtask

  task automatic send_frame(input logic [DB-1:0] d, input logic par, input logic stop);
    send_body(d, par);
    send_bit(stop);
    rx = 1'b1;
  endtask

  function automatic logic even_par(input logic [DB-1:0] d);
    return (($countones(d) % 2) == 1);
  endfunction

  // Reference model: outcome of a frame with the consumer always ready.
  task automatic send_and_model(input logic [DB-1:0] d, input logic par, input logic stop);
    if (!stop) fe_exp++;
`ifdef UART_RX_PARITY_EN
    else if ((($countones(d) + int'(par)) % 2) != PARITY_ODD_TB) pe_exp++;
`endif
    else exp_q.push_back(d);
    send_frame(d, par, stop);
    hold(BIT_CLKS * $urandom_range(1, 3));
  endtask

  // Raises rx_ready for exactly the clock whose edge samples the stop bit.
  task automatic pulse_at_stop();
    int n = 0;
    int guard = 0;
    wait_state(ST_STOP, 12 * BIT_CLKS, "coin_reach_stop");
    while (n < OS && guard < 2 * BIT_CLKS) begin
      if (baud_tick) n++;
      if (n < OS) begin
        step();
        guard++;
      end
    end
    rx_ready = 1'b1;
    step();
    rx_ready = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int v0;
    logic [DB-1:0] d;
    logic stop;
    logic par;

    // reset
    #1 reset_n = 1'b0;
    hold(5);
    check("rst_valid", rx_valid, 1'b0);
    check("rst_data", rx_data, '0);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_state", rx_state, ST_IDLE);
`ifdef UART_RX_PARITY_EN
    check("rst_parity_err", parity_err, 1'b0);
`endif
    reset_n = 1'b1;
    hold(BIT_CLKS);

    // basic frames, consumer ready: one valid clock each
    v0 = valid_cycles;
    send_and_model(8'hA5, even_par(8'hA5), 1'b1);
    send_and_model(8'h00, even_par(8'h00), 1'b1);
    send_and_model(8'hFF, even_par(8'hFF), 1'b1);
    check("valid_one_clk", valid_cycles - v0, 3);
    check_sb("basic");

    // random frames, some with a bad stop bit or a flipped parity bit
    for (int i = 0; i < 12; i++) begin
      d    = DB'($urandom_range(0, 255));
      stop = ($urandom_range(0, 3) != 0);
      par  = even_par(d) ^ ($urandom_range(0, 3) == 0);
      send_and_model(d, par, stop);
    end
    check_sb("random");

    // start glitch: low for 4 ticks only
    rx = 1'b0;
    hold(4 * TICK_DIV);
    check("glitch_busy", busy, 1'b1);
    rx = 1'b1;
    hold(2 * BIT_CLKS);
    check("glitch_idle", rx_state, ST_IDLE);
    check("glitch_valid", rx_valid, 1'b0);
    check_sb("glitch");

    // stop bit 0 followed by a held-low line
    fe_exp++;
    send_body(8'h3C, even_par(8'h3C));
    rx = 1'b0;
    hold(3 * BIT_CLKS);
    check("break_state", rx_state, ST_BREAK);
    check("break_ferr", fe_cnt, fe_exp);
    rx = 1'b1;
    hold(BIT_CLKS);
    check("break_exit", rx_state, ST_IDLE);
    send_and_model(8'h55, even_par(8'h55), 1'b1);
    check_sb("break");

    // overrun: consumer stalled across two frames
    rx_ready = 1'b0;
    send_frame(8'h11, even_par(8'h11), 1'b1);
    hold(BIT_CLKS);
    send_frame(8'h22, even_par(8'h22), 1'b1);
    hold(BIT_CLKS);
    ov_exp++;
    check("ovr_valid", rx_valid, 1'b1);
    check("ovr_data", rx_data, 8'h11);
    rx_ready = 1'b1;
    exp_q.push_back(8'h11);
    hold(2);
    check("ovr_drained", rx_valid, 1'b0);
    check_sb("overrun");

    // accept in the very clock the next frame completes: no overrun
    rx_ready = 1'b0;
    send_frame(8'h11, even_par(8'h11), 1'b1);
    hold(BIT_CLKS);
    exp_q.push_back(8'h11);
    fork
      send_frame(8'h22, even_par(8'h22), 1'b1);
      pulse_at_stop();
    join
    hold(BIT_CLKS);
    check("coin_valid", rx_valid, 1'b1);
    check("coin_data", rx_data, 8'h22);
    exp_q.push_back(8'h22);
    rx_ready = 1'b1;
    hold(2);
    check("coin_drained", rx_valid, 1'b0);
    check_sb("coincide");

    // reset in the middle of a frame while a byte is pending
    rx_ready = 1'b0;
    send_frame(8'h5A, even_par(8'h5A), 1'b1);
    hold(BIT_CLKS);
    d = 8'h0F;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(d[i]);
    rx = d[4];
    hold(BIT_CLKS / 2);
    check("pre_rst_busy", busy, 1'b1);
    check("pre_rst_valid", rx_valid, 1'b1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_valid", rx_valid, 1'b0);
    check("mid_rst_data", rx_data, '0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_state", rx_state, ST_IDLE);
    rx = 1'b1;
    hold(4);
    reset_n  = 1'b1;
    rx_ready = 1'b1;
    hold(BIT_CLKS);
    send_and_model(8'hC3, even_par(8'hC3), 1'b1);
    check_sb("reset");

`ifdef UART_RX_PARITY_EN
    // even parity: 0x07 needs parity bit 1
    send_and_model(8'h07, 1'b1, 1'b1);
    send_and_model(8'h07, 1'b0, 1'b1);
    check_sb("parity");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
